// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle with master/slave modports.
// Connects an AXI4 master to axi_mem_slave.
interface axi_mem_slave_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [5:0]                  aw_atop;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by a register-array memory; independent write and read FSMs,
// one outstanding transaction per direction, OKAY/SLVERR/DECERR responses.
module axi_mem_slave #(
  parameter int unsigned                AXI_ADDR_WIDTH = 64,
  parameter int unsigned                AXI_DATA_WIDTH = 64,
  parameter int unsigned                AXI_ID_WIDTH   = 4,
  parameter int unsigned                NumWords       = 256,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BaseAddr       = '0
) (
  input logic             clk_i,
  input logic             rst_i,
  axi_mem_slave_if.Slave  slv
);
  localparam int unsigned Lanes = AXI_DATA_WIDTH / 8;
  localparam int unsigned Shift = $clog2(Lanes);
  localparam int unsigned IdxW  = $clog2(NumWords);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef logic [AXI_DATA_WIDTH-1:0] data_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic in_range(input addr_t a);
    return (a >= BaseAddr) && (((a - BaseAddr) >> Shift) < addr_t'(NumWords));
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input addr_t a);
    return IdxW'((a - BaseAddr) >> Shift);
  endfunction

  function automatic addr_t next_addr(input addr_t a, input logic [2:0] size,
                                      input logic [1:0] burst);
    addr_t step;
    step = addr_t'(1) << size;
    if (burst == BurstFixed) return a;
    return (a & ~(step - addr_t'(1))) + step;
  endfunction

  data_t mem [NumWords];

  w_state_e                w_state;
  addr_t                   w_addr;
  logic [7:0]              w_len, w_cnt;
  logic [2:0]              w_size;
  logic [1:0]              w_burst;
  logic [AXI_ID_WIDTH-1:0] w_id;
  logic                    w_dec, w_slv, w_bad;
  logic                    w_hit, w_last_beat, w_dec_nx, w_slv_nx;
  logic [IdxW-1:0]         w_idx;

  r_state_e                r_state;
  addr_t                   r_addr, rd_addr;
  logic [7:0]              r_len, r_cnt;
  logic [2:0]              r_size;
  logic [1:0]              r_burst, rd_burst, rd_resp;
  logic                    rd_hit;
  data_t                   rd_word;

  logic unused_sig;
  assign unused_sig = ^{slv.aw_lock, slv.aw_cache, slv.aw_prot, slv.aw_qos, slv.aw_region,
                        slv.aw_user, slv.w_user, slv.ar_lock, slv.ar_cache, slv.ar_prot,
                        slv.ar_qos, slv.ar_region, slv.ar_user};

  assign slv.b_user = '0;
  assign slv.r_user = '0;

  always_comb begin
    w_hit       = in_range(w_addr);
    w_idx       = word_idx(w_addr);
    w_last_beat = (w_cnt == w_len);
    // Unsupported bursts answer SLVERR only, so they never raise the decode flag.
    w_dec_nx    = w_dec | (~w_hit & ~w_bad);
    w_slv_nx    = w_slv | (slv.w_last != w_last_beat);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state      <= W_IDLE;
      slv.aw_ready <= 1'b1;
      slv.w_ready  <= 1'b0;
      slv.b_valid  <= 1'b0;
      slv.b_id     <= '0;
      slv.b_resp   <= '0;
      w_addr       <= '0;
      w_len        <= '0;
      w_cnt        <= '0;
      w_size       <= '0;
      w_burst      <= '0;
      w_id         <= '0;
      w_dec        <= 1'b0;
      w_slv        <= 1'b0;
      w_bad        <= 1'b0;
      for (int unsigned i = 0; i < NumWords; i++) mem[i] <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (slv.aw_valid && slv.aw_ready) begin
          w_addr       <= slv.aw_addr;
          w_len        <= slv.aw_len;
          w_size       <= slv.aw_size;
          w_burst      <= slv.aw_burst;
          w_id         <= slv.aw_id;
          w_cnt        <= '0;
          w_dec        <= 1'b0;
          w_bad        <= (slv.aw_burst == BurstWrap) || (slv.aw_atop != '0);
          w_slv        <= (slv.aw_burst == BurstWrap) || (slv.aw_atop != '0);
          slv.aw_ready <= 1'b0;
          slv.w_ready  <= 1'b1;
          w_state      <= W_DATA;
        end
        W_DATA: if (slv.w_valid && slv.w_ready) begin
          if (w_hit && !w_bad) begin
            for (int unsigned b = 0; b < Lanes; b++)
              if (slv.w_strb[b]) mem[w_idx][8*b +: 8] <= slv.w_data[8*b +: 8];
          end
          w_addr <= next_addr(w_addr, w_size, w_burst);
          w_cnt  <= w_cnt + 8'd1;
          w_dec  <= w_dec_nx;
          w_slv  <= w_slv_nx;
          if (w_last_beat) begin
            slv.w_ready <= 1'b0;
            slv.b_valid <= 1'b1;
            slv.b_id    <= w_id;
            slv.b_resp  <= w_dec_nx ? RespDecerr : (w_slv_nx ? RespSlverr : RespOkay);
            w_state     <= W_RESP;
          end
        end
        W_RESP: if (slv.b_ready) begin
          slv.b_valid  <= 1'b0;
          slv.aw_ready <= 1'b1;
          w_state      <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // One lookup serves both the first beat (from AR) and every following beat.
  always_comb begin
    rd_addr  = (r_state == R_IDLE) ? slv.ar_addr  : next_addr(r_addr, r_size, r_burst);
    rd_burst = (r_state == R_IDLE) ? slv.ar_burst : r_burst;
    rd_hit   = in_range(rd_addr);
    rd_word  = '0;
    if (rd_hit && rd_burst != BurstWrap) rd_word = mem[word_idx(rd_addr)];
    rd_resp  = !rd_hit ? RespDecerr : ((rd_burst == BurstWrap) ? RespSlverr : RespOkay);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= R_IDLE;
      slv.ar_ready <= 1'b1;
      slv.r_valid  <= 1'b0;
      slv.r_id     <= '0;
      slv.r_data   <= '0;
      slv.r_resp   <= '0;
      slv.r_last   <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (slv.ar_valid && slv.ar_ready) begin
          r_addr       <= slv.ar_addr;
          r_len        <= slv.ar_len;
          r_size       <= slv.ar_size;
          r_burst      <= slv.ar_burst;
          r_cnt        <= '0;
          slv.r_id     <= slv.ar_id;
          slv.r_data   <= rd_word;
          slv.r_resp   <= rd_resp;
          slv.r_last   <= (slv.ar_len == 8'd0);
          slv.r_valid  <= 1'b1;
          slv.ar_ready <= 1'b0;
          r_state      <= R_DATA;
        end
        R_DATA: if (slv.r_ready) begin
          if (slv.r_last) begin
            slv.r_valid  <= 1'b0;
            slv.r_last   <= 1'b0;
            slv.ar_ready <= 1'b1;
            r_state      <= R_IDLE;
          end else begin
            r_addr     <= rd_addr;
            r_cnt      <= r_cnt + 8'd1;
            slv.r_data <= rd_word;
            slv.r_resp <= rd_resp;
            slv.r_last <= ((r_cnt + 8'd1) == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule
